// File: rtl/polybius_pkg.sv
// Shared definitions for the Polybius stream cipher.
// - The "DANIEL"-keyed 5x5 square, with J folded onto I. It is held as a
//   26-entry letter->code table and a 25-entry square for code->letter.
// - ASCII bounds, the FSM state type and the lookup result struct.
// Codes are decimal row*10+col, each digit 1..5 (D=11 ... Z=55).
package polybius_pkg;

  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_Z = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [7:0] val;
  } lut_res_t;

  // Indexed by letter - 'A'. J shares I's code.
  localparam logic [7:0] CODE_TABLE [26] = '{
    8'd12, 8'd22, 8'd23, 8'd11, 8'd15, 8'd24, 8'd25, 8'd31, 8'd14,
    8'd14, 8'd32, 8'd21, 8'd33, 8'd13, 8'd34, 8'd35, 8'd41, 8'd42,
    8'd43, 8'd44, 8'd45, 8'd51, 8'd52, 8'd53, 8'd54, 8'd55
  };

  // Row-major square. Index (row-1)*5 + (col-1).
  localparam logic [7:0] SQUARE [25] = '{
    "D", "A", "N", "I", "E",
    "L", "B", "C", "F", "G",
    "H", "K", "M", "O", "P",
    "Q", "R", "S", "T", "U",
    "V", "W", "X", "Y", "Z"
  };

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

  function automatic lut_res_t letter_to_code(input logic [7:0] c);
    lut_res_t   r;
    logic [4:0] off;
    off   = 5'(c - ASCII_A);
    r.vld = is_letter(c);
    r.val = r.vld ? CODE_TABLE[off] : 8'd0;
    return r;
  endfunction

  // A code is only a letter if both decimal digits lie in 1..5.
  function automatic lut_res_t code_to_letter(input logic [7:0] code);
    lut_res_t   r;
    logic [7:0] tens;
    logic [7:0] units;
    logic [4:0] idx;
    tens  = code / 8'd10;
    units = code % 8'd10;
    r.vld = (tens >= 8'd1) && (tens <= 8'd5) && (units >= 8'd1) && (units <= 8'd5);
    idx   = 5'((tens - 8'd1) * 8'd5 + (units - 8'd1));
    r.val = r.vld ? SQUARE[idx] : 8'd0;
    return r;
  endfunction

endpackage

// File: rtl/polybius_lut.sv
// Combinational Polybius lookup in either direction.
// Ports:
//   enc_i  : 1 = letter->code, 0 = code->letter
//   data_i : ASCII letter or decimal code
//   data_o : code or letter; 0 when invalid
//   vld_o  : input was a legal letter / code
module polybius_lut
  import polybius_pkg::*;
(
  input  logic       enc_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       vld_o
);

  lut_res_t res;

  always_comb begin
    res = enc_i ? letter_to_code(data_i) : code_to_letter(data_i);
  end

  assign data_o = res.val;
  assign vld_o  = res.vld;

endmodule

// File: rtl/polybius_stream_cipher.sv
// Streaming Polybius cipher. Each byte is encrypted or decrypted against a
// serially loaded secret, one byte per cycle with a latency of one.
// Ports:
//   i_w_clk, i_w_rst_n            : clock, async active-low reset
//   i_w_key_start/valid/data/last : secret load stream (restart + bytes)
//   o_w_key_loaded, o_r_key_err   : secret usable / sticky load error
//   i_w_in_valid/data/mode/last, o_w_in_ready     : text/cipher input
//   o_r_out_valid/data/last/err, i_w_out_ready    : registered result
module polybius_stream_cipher
  import polybius_pkg::*;
#(
  parameter int p_secret_max_length = 16,
  parameter int p_lut_registered    = 0
) (
  input  logic       i_w_clk,
  input  logic       i_w_rst_n,
  input  logic       i_w_key_start,
  input  logic       i_w_key_valid,
  input  logic [7:0] i_w_key_data,
  input  logic       i_w_key_last,
  output logic       o_w_key_loaded,
  output logic       o_r_key_err,
  input  logic       i_w_in_valid,
  output logic       o_w_in_ready,
  input  logic [7:0] i_w_in_data,
  input  logic       i_w_in_mode,
  input  logic       i_w_in_last,
  output logic       o_r_out_valid,
  input  logic       i_w_out_ready,
  output logic [7:0] o_r_out_data,
  output logic       o_r_out_last,
  output logic       o_r_out_err
);

  localparam int IW = (p_secret_max_length > 1) ? $clog2(p_secret_max_length) : 1;
  localparam int LW = $clog2(p_secret_max_length + 1);

  generate
    if (p_lut_registered != 0) begin : g_lut_reg_reserved
      $error("p_lut_registered = 1 is reserved; only 0 is implemented");
    end
  endgenerate

  state_e        state_q;
  logic [7:0]    key_q [p_secret_max_length];
  logic [LW-1:0] key_len_q;
  logic          key_err_q;
  logic [IW-1:0] kidx_q;
  logic          out_valid_q, out_last_q, out_err_q;
  logic [7:0]    out_data_q;

  // Lookups: key letter -> code, and data letter -> code or difference -> letter.
  logic [7:0] key_code, dec_diff, data_lut_in, data_lut_out;
  logic       key_code_vld, data_lut_vld;

  assign dec_diff    = i_w_in_data - key_code;
  assign data_lut_in = i_w_in_mode ? i_w_in_data : dec_diff;

  polybius_lut u_key_lut (
    .enc_i  (1'b1),
    .data_i (key_q[kidx_q]),
    .data_o (key_code),
    .vld_o  (key_code_vld)
  );

  polybius_lut u_data_lut (
    .enc_i  (i_w_in_mode),
    .data_i (data_lut_in),
    .data_o (data_lut_out),
    .vld_o  (data_lut_vld)
  );

  logic       res_err;
  logic [7:0] res_data;

  // The unsigned difference wraps on underflow, so underflow is flagged
  // before the digit check.
  always_comb begin
    res_err  = !key_code_vld || !data_lut_vld ||
               (!i_w_in_mode && (i_w_in_data < key_code));
    res_data = 8'd0;
    if (!res_err) res_data = i_w_in_mode ? (data_lut_out + key_code) : data_lut_out;
  end

  logic accept, kidx_wrap, key_wr_ok;

  assign o_w_key_loaded = (state_q == ST_RUN);
  assign o_w_in_ready   = (state_q == ST_RUN) && (!out_valid_q || i_w_out_ready);
  assign accept         = i_w_in_valid && o_w_in_ready;
  assign kidx_wrap      = (LW'(kidx_q) == key_len_q - LW'(1));
  assign key_wr_ok      = (key_len_q < LW'(p_secret_max_length)) && is_letter(i_w_key_data);

  // Key FSM and key RAM. key_start wins over everything, in every state.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      state_q   <= ST_IDLE;
      key_len_q <= '0;
      key_err_q <= 1'b0;
      for (int i = 0; i < p_secret_max_length; i++) key_q[i] <= 8'd0;
    end else if (i_w_key_start) begin
      state_q   <= ST_LOAD;
      key_len_q <= '0;
      key_err_q <= 1'b0;
    end else if (state_q == ST_LOAD && i_w_key_valid) begin
      if (!key_wr_ok) begin
        state_q   <= ST_IDLE;
        key_err_q <= 1'b1;
      end else begin
        key_q[key_len_q[IW-1:0]] <= i_w_key_data;
        key_len_q                <= key_len_q + LW'(1);
        if (i_w_key_last) state_q <= ST_RUN;
      end
    end
  end

  // Output stage and key index. A new key drops any pending result.
  always_ff @(posedge i_w_clk or negedge i_w_rst_n) begin
    if (!i_w_rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      kidx_q      <= '0;
    end else if (i_w_key_start) begin
      out_valid_q <= 1'b0;
      kidx_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= res_data;
      out_last_q  <= i_w_in_last;
      out_err_q   <= res_err;
      kidx_q      <= (i_w_in_last || kidx_wrap) ? '0 : kidx_q + IW'(1);
    end else if (i_w_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign o_r_key_err   = key_err_q;
  assign o_r_out_valid = out_valid_q;
  assign o_r_out_data  = out_data_q;
  assign o_r_out_last  = out_last_q;
  assign o_r_out_err   = out_err_q;

endmodule

// File: tb/tb_polybius_stream_cipher.sv
module tb_polybius_stream_cipher;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_start, key_valid, key_last;
  logic [7:0] key_data;
  logic       key_loaded, key_err;
  logic       in_valid, in_ready, in_mode, in_last;
  logic [7:0] in_data;
  logic       out_valid, out_ready, out_last, out_err;
  logic [7:0] out_data;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  polybius_stream_cipher dut (
    .i_w_clk        (clk),
    .i_w_rst_n      (rst_n),
    .i_w_key_start  (key_start),
    .i_w_key_valid  (key_valid),
    .i_w_key_data   (key_data),
    .i_w_key_last   (key_last),
    .o_w_key_loaded (key_loaded),
    .o_r_key_err    (key_err),
    .i_w_in_valid   (in_valid),
    .o_w_in_ready   (in_ready),
    .i_w_in_data    (in_data),
    .i_w_in_mode    (in_mode),
    .i_w_in_last    (in_last),
    .o_r_out_valid  (out_valid),
    .i_w_out_ready  (out_ready),
    .o_r_out_data   (out_data),
    .o_r_out_last   (out_last),
    .o_r_out_err    (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input string s, input logic exp_ok);
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      key_valid = 1'b1;
      key_data  = s[i];
      key_last  = (i == s.len() - 1);
      tick();
    end
    key_valid = 1'b0;
    key_last  = 1'b0;
    check($sformatf("key_loaded[%s]", s), key_loaded, exp_ok);
    check($sformatf("key_err[%s]", s), key_err, !exp_ok);
  endtask

  // One byte through with downstream always ready; result checked next cycle.
  task automatic xfer(input logic mode, input logic [7:0] d, input logic last,
                      input logic [7:0] exp_d, input logic exp_e, input string tag);
    int n;
    n         = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = mode;
    in_data   = d;
    in_last   = last;
    #1;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready_timeout"}, (n >= 20), 0);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_err"}, out_err, exp_e);
    check({tag, "_last"}, out_last, last);
  endtask

  logic [7:0] ct [27] = '{55, 27, 66, 58, 45, 46, 23, 54, 57, 29, 42, 57, 24, 37,
                          24, 29, 54, 57, 32, 56, 28, 35, 35, 56, 26, 54, 28};
  logic [7:0] enc7 [7] = '{23, 24, 25, 26, 33, 24, 23};
  logic [7:0] encl [4] = '{23, 24, 25, 23};
  string pt = "TEXTFOARTELUNGDEMULTELITERE";

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; key_start = 0; key_valid = 0; key_last = 0; key_data = 0;
    in_valid = 0; in_mode = 0; in_last = 0; in_data = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_flags", {out_valid, out_last, out_err, key_err, key_loaded, in_ready}, 0);
    check("rst_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    // Decrypt the reference message.
    load_key("DANILA", 1);
    for (int i = 0; i < 27; i++)
      xfer(1'b0, ct[i], (i == 26), pt[i], 1'b0, $sformatf("dec[%0d]", i));

    // Single-letter key: encrypt and decrypt edge cases.
    load_key("D", 1);
    xfer(1'b1, "T", 1'b0, 8'd55, 1'b0, "enc_T");
    xfer(1'b1, "J", 1'b0, 8'd25, 1'b0, "enc_J");
    xfer(1'b1, "7", 1'b0, 8'd0,  1'b1, "enc_7");
    xfer(1'b0, 8'd16, 1'b0, 8'd0, 1'b1, "dec_16");
    xfer(1'b0, 8'd5,  1'b0, 8'd0, 1'b1, "dec_5");
    xfer(1'b0, 8'd55, 1'b0, "T",  1'b0, "dec_55");

    // Key index wrap, then restart on in_last.
    load_key("DANILA", 1);
    for (int i = 0; i < 7; i++)
      xfer(1'b1, "A", 1'b0, enc7[i], 1'b0, $sformatf("wrap[%0d]", i));
    load_key("DANILA", 1);
    for (int i = 0; i < 4; i++)
      xfer(1'b1, "A", (i == 2), encl[i], 1'b0, $sformatf("last[%0d]", i));

    // Backpressure: hold one result for 3 cycles, then release.
    load_key("DANILA", 1);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_mode = 1'b1; in_data = "A"; in_last = 1'b0;
    #1;
    check("bp_ready_first", in_ready, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_hold_ready[%0d]", i), in_ready, 0);
      check($sformatf("bp_hold_valid[%0d]", i), out_valid, 1);
      check($sformatf("bp_hold_data[%0d]", i), out_data, 23);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_next_data", out_data, 24);
    check("bp_next_valid", out_valid, 1);

    // key_start while a result is pending drops it.
    out_ready = 1'b0;
    key_start = 1'b1;
    tick();
    key_start = 1'b0;
    check("ks_drop_valid", out_valid, 0);
    check("ks_loaded", key_loaded, 0);

    // Bad key letter and overlength key.
    load_key("DA1", 0);
    load_key({"AAAAAAAAAA", "AAAAAAA"}, 0);

    // Asynchronous reset with a result pending.
    load_key("DANILA", 1);
    out_ready = 1'b0;
    in_valid  = 1'b1; in_mode = 1'b1; in_data = "A"; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    check("ar_pre_data", out_data, 23);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_flags", {out_valid, out_last, out_err, key_err, key_loaded, in_ready}, 0);
    check("ar_data", out_data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_need_reload", key_loaded, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
